// File: rtl/cpu0_pkg.sv
// cpu0_pkg: shared definitions for the CPU0 memory path.
//   - state_e      : controller FSM encoding (IDLE/XFER/DONE)
//   - CPU0_WORD_W  : CPU word width (32)
//   - CPU0_BYTE_W  : memory port width (8)
//   - RW_READ/RW_WRITE : direction encodings on req_rw / mem_rw
//   - lane_sel()   : maps a byte counter to its packed-word lane (big-endian)
package cpu0_pkg;

  localparam int CPU0_WORD_W = 32;
  localparam int CPU0_BYTE_W = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Byte 0 of a transfer lives in bits 31:24, i.e. packed lane 3.
  function automatic logic [1:0] lane_sel(input logic [1:0] byte_cnt);
    return 2'd3 - byte_cnt;
  endfunction

endpackage

// File: rtl/cpu0_mem_ctrl_if.sv
// cpu0_mem_ctrl_if: CPU request handshake plus byte-wide memory port.
//   req_en/req_rw/req_addr/req_wdata : CPU -> controller
//   req_rdata/req_ready/req_err      : controller -> CPU
//   mem_en/mem_rw/mem_addr/mem_wdata : controller -> byte memory
//   mem_rdata                        : byte memory -> controller (combinational)
// Modports: master = CPU side, slave = controller, mem = byte memory.
interface cpu0_mem_ctrl_if import cpu0_pkg::*; ();

  logic                   req_en;
  logic                   req_rw;
  logic [CPU0_WORD_W-1:0] req_addr;
  logic [CPU0_WORD_W-1:0] req_wdata;
  logic [CPU0_WORD_W-1:0] req_rdata;
  logic                   req_ready;
  logic                   req_err;

  logic                   mem_en;
  logic                   mem_rw;
  logic [CPU0_WORD_W-1:0] mem_addr;
  logic [CPU0_BYTE_W-1:0] mem_wdata;
  logic [CPU0_BYTE_W-1:0] mem_rdata;

  modport master (
    output req_en, req_rw, req_addr, req_wdata,
    input  req_rdata, req_ready, req_err
  );

  modport slave (
    input  req_en, req_rw, req_addr, req_wdata,
    output req_rdata, req_ready, req_err,
    output mem_en, mem_rw, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport mem (
    input  mem_en, mem_rw, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/cpu0_mem_byte_seq.sv
// cpu0_mem_byte_seq: byte/wait-state sequencer for one word transfer.
//   clock, reset : rising-edge clock, async active-low reset
//   start        : clears the counters (request accepted)
//   run          : controller is in XFER; counters advance
//   lane         : current byte index 0..3 within the word
//   phase_last   : last cycle of the current byte phase
//   last_byte    : last cycle of byte 3 (transfer complete)
// Each byte phase lasts WAIT_STATES+1 cycles.
module cpu0_mem_byte_seq #(
  parameter int WAIT_STATES = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       run,
  output logic [1:0] lane,
  output logic       phase_last,
  output logic       last_byte
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic [1:0] byte_cnt;
  logic [3:0] wait_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_cnt <= '0;
      wait_cnt <= '0;
    end else if (start) begin
      byte_cnt <= '0;
      wait_cnt <= '0;
    end else if (run) begin
      if (phase_last) begin
        // byte_cnt wraps 3->0 after the final byte, leaving it clean for next time
        wait_cnt <= '0;
        byte_cnt <= byte_cnt + 2'd1;
      end else begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

  assign lane       = byte_cnt;
  assign phase_last = (wait_cnt == WS);
  assign last_byte  = run && phase_last && (byte_cnt == 2'd3);

endmodule

// File: rtl/cpu0_mem_ctrl.sv
// cpu0_mem_ctrl: word-to-byte memory controller for CPU0.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset; aborts any transfer, all outputs 0
//   bus   : cpu0_mem_ctrl_if.slave (CPU request handshake + byte memory port)
// A 32-bit request is run as four big-endian byte transfers (addr..addr+3,
// byte at addr = bits 31:24), then a one-cycle DONE pulses req_ready.
// Out-of-range addresses (addr > MEM_BYTES-4) skip XFER and report req_err.
// Optional build macro CPU0_MEM_ALIGN_CHECK_EN: also reject addr[1:0] != 0.
module cpu0_mem_ctrl import cpu0_pkg::*; #(
  parameter int MEM_BYTES   = 128,
  parameter int WAIT_STATES = 0
) (
  input  logic            clock,
  input  logic            reset,
  cpu0_mem_ctrl_if.slave  bus
);

  localparam logic [CPU0_WORD_W-1:0] MAX_ADDR = CPU0_WORD_W'(MEM_BYTES - 4);

  state_e state_q, state_d;

  logic                              rw_q;
  logic                              err_q;
  logic [CPU0_WORD_W-1:0]            addr_q;
  logic [3:0][CPU0_BYTE_W-1:0]       wdata_q;
  logic [3:0][CPU0_BYTE_W-1:0]       rdata_q;

  logic       accept;
  logic       addr_bad;
  logic       in_xfer;
  logic [1:0] lane;
  logic       phase_last;
  logic       last_byte;

  assign accept  = (state_q == ST_IDLE) && bus.req_en;
  assign in_xfer = (state_q == ST_XFER);

`ifdef CPU0_MEM_ALIGN_CHECK_EN
  assign addr_bad = (bus.req_addr > MAX_ADDR) || (bus.req_addr[1:0] != 2'b00);
`else
  assign addr_bad = (bus.req_addr > MAX_ADDR);
`endif

  cpu0_mem_byte_seq #(.WAIT_STATES(WAIT_STATES)) u_seq (
    .clock      (clock),
    .reset      (reset),
    .start      (accept),
    .run        (in_xfer),
    .lane       (lane),
    .phase_last (phase_last),
    .last_byte  (last_byte)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.req_en) state_d = addr_bad ? ST_DONE : ST_XFER;
      ST_XFER: if (last_byte)  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch and read-word assembly. rdata_q is cleared on accept so a
  // write or a rejected access presents 0 in DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rw_q    <= RW_WRITE;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      rw_q    <= bus.req_rw;
      err_q   <= addr_bad;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      rdata_q <= '0;
    end else if (in_xfer && phase_last && (rw_q == RW_READ)) begin
      rdata_q[lane_sel(lane)] <= bus.mem_rdata;
    end
  end

  // Outputs decode purely from the registered state, so an async reset
  // forces every output to 0 without waiting for a clock.
  always_comb begin
    bus.req_rdata = '0;
    bus.req_ready = 1'b0;
    bus.req_err   = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_rw    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state_q)
      ST_XFER: begin
        bus.mem_en    = 1'b1;
        bus.mem_rw    = rw_q;
        bus.mem_addr  = addr_q + {30'd0, lane};
        bus.mem_wdata = wdata_q[lane_sel(lane)];
      end
      ST_DONE: begin
        bus.req_ready = 1'b1;
        bus.req_rdata = rdata_q;
        bus.req_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu0_mem_ctrl.sv
// tb_cpu0_mem_ctrl: self-checking bench for cpu0_mem_ctrl.
// Two instances: dut0 (WAIT_STATES=0) and dut2 (WAIT_STATES=2), each with its
// own byte memory model. Expected results go into a scoreboard queue when a
// request is issued and are popped and compared when req_ready arrives.
module tb_cpu0_mem_ctrl;
  import cpu0_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  cpu0_mem_ctrl_if if0 ();
  cpu0_mem_ctrl_if if2 ();

  cpu0_mem_ctrl #(.MEM_BYTES(128), .WAIT_STATES(0)) dut0 (
    .clock (clock), .reset (reset), .bus (if0.slave));
  cpu0_mem_ctrl #(.MEM_BYTES(128), .WAIT_STATES(2)) dut2 (
    .clock (clock), .reset (reset), .bus (if2.slave));

  // byte memories with a preload port
  logic [7:0] mem0 [128];
  logic [7:0] mem2 [128];
  logic       pl_en0 = 1'b0, pl_en2 = 1'b0;
  logic [6:0] pl_addr = '0;
  logic [7:0] pl_data = '0;

  assign if0.mem_rdata = (if0.mem_addr < 32'd128) ? mem0[if0.mem_addr[6:0]] : 8'h00;
  assign if2.mem_rdata = (if2.mem_addr < 32'd128) ? mem2[if2.mem_addr[6:0]] : 8'h00;

  always @(posedge clock) begin
    if (pl_en0) mem0[pl_addr] <= pl_data;
    else if (if0.mem_en && !if0.mem_rw) mem0[if0.mem_addr[6:0]] <= if0.mem_wdata;
    if (pl_en2) mem2[pl_addr] <= pl_data;
    else if (if2.mem_en && !if2.mem_rw) mem2[if2.mem_addr[6:0]] <= if2.mem_wdata;
  end

  // monitors
  int          en_cnt0 = 0;
  int          en_cnt2 = 0;
  logic [31:0] addr_log2 [$];
  always @(negedge clock) begin
    if (if0.mem_en) en_cnt0 <= en_cnt0 + 1;
    if (if2.mem_en) begin
      en_cnt2 <= en_cnt2 + 1;
      addr_log2.push_back(if2.mem_addr);
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb [$];

  int total = 0;
  int bad   = 0;

  task automatic drive(input bit sel, input logic en, input logic rw,
                       input logic [31:0] a, input logic [31:0] w);
    if (sel) begin
      if2.req_en = en; if2.req_rw = rw; if2.req_addr = a; if2.req_wdata = w;
    end else begin
      if0.req_en = en; if0.req_rw = rw; if0.req_addr = a; if0.req_wdata = w;
    end
  endtask

  task automatic preload(input bit sel, input logic [6:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      pl_addr = 7'(a + 7'(i));
      pl_data = w[31-8*i -: 8];
      if (sel) pl_en2 = 1'b1; else pl_en0 = 1'b1;
    end
    @(negedge clock);
    pl_en0 = 1'b0;
    pl_en2 = 1'b0;
  endtask

  // Issue one request, wait (bounded) for req_ready. lat counts edges from the
  // accept edge to the edge that samples req_ready=1. With poke set, the req_*
  // inputs are scrambled and req_en dropped mid-transfer.
  task automatic run_req(input bit sel, input logic rw, input logic [31:0] a,
                         input logic [31:0] w, input bit poke,
                         output logic [31:0] rd, output logic er, output int lat);
    int  n;
    bit  got;
    bit  leak;
    logic rdy;
    @(negedge clock);
    drive(sel, 1'b1, rw, a, w);
    @(posedge clock);
    n = 0; got = 0; leak = 0; rd = '0; er = 1'b0; lat = -1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clock);
      rdy = sel ? if2.req_ready : if0.req_ready;
      if (rdy) begin
        got = 1;
        lat = n + 1;
        rd  = sel ? if2.req_rdata : if0.req_rdata;
        er  = sel ? if2.req_err   : if0.req_err;
      end else begin
        if (sel ? (if2.req_rdata != 0 || if2.req_err) : (if0.req_rdata != 0 || if0.req_err))
          leak = 1;
        if (poke && n == 1) drive(sel, 1'b0, ~rw, 32'h50, ~w);
        @(posedge clock);
        n++;
      end
    end
    drive(sel, 1'b0, rw, a, w);
    total++;
    if (!got) begin
      bad++;
      $display("FAIL ready_timeout addr=%h: no req_ready within 200 cycles", a);
    end
    total++;
    if (leak !== 1'b0) begin
      bad++;
      $display("FAIL idle_outputs addr=%h: rdata/err nonzero while ready=0", a);
    end
    @(posedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    total++;
    if ({if0.req_ready, if0.req_err, if0.req_rdata, if0.mem_en, if0.mem_rw,
         if0.mem_addr, if0.mem_wdata} !== 76'd0) begin
      bad++;
      $display("FAIL reset_outputs_dut0 got ready=%b mem_en=%b addr=%h want all 0",
               if0.req_ready, if0.mem_en, if0.mem_addr);
    end
    total++;
    if ({if2.req_ready, if2.req_err, if2.req_rdata, if2.mem_en, if2.mem_rw,
         if2.mem_addr, if2.mem_wdata} !== 76'd0) begin
      bad++;
      $display("FAIL reset_outputs_dut2 got ready=%b mem_en=%b addr=%h want all 0",
               if2.req_ready, if2.mem_en, if2.mem_addr);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_read_basic();
    logic [31:0] rd; logic er; int lt; exp_t e; int base;
    preload(0, 7'h1C, 32'h0000_0001);
    base = en_cnt0;
    sb.push_back('{rdata: 32'h0000_0001, err: 1'b0, lat: 5});
    run_req(0, RW_READ, 32'h1C, 32'h0, 0, rd, er, lt);
    e = sb.pop_front();
    total++; if (rd !== e.rdata) begin bad++; $display("FAIL read_1c_rdata got %h want %h", rd, e.rdata); end
    total++; if (er !== e.err)   begin bad++; $display("FAIL read_1c_err got %b want %b", er, e.err); end
    total++; if (lt !== e.lat)   begin bad++; $display("FAIL read_1c_latency got %0d want %0d", lt, e.lat); end
    total++; if (en_cnt0 - base !== 4) begin bad++; $display("FAIL read_1c_mem_en got %0d want 4", en_cnt0 - base); end
  endtask

  task automatic test_write_readback();
    logic [31:0] rd; logic er; int lt; exp_t e;
    sb.push_back('{rdata: 32'h0, err: 1'b0, lat: 5});
    run_req(0, RW_WRITE, 32'h20, 32'h1234_5678, 0, rd, er, lt);
    e = sb.pop_front();
    total++; if (rd !== e.rdata || er !== e.err) begin bad++; $display("FAIL write_20_resp got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
    total++; if (lt !== e.lat) begin bad++; $display("FAIL write_20_latency got %0d want %0d", lt, e.lat); end
    total++;
    if ({mem0[32], mem0[33], mem0[34], mem0[35]} !== 32'h1234_5678) begin
      bad++;
      $display("FAIL write_20_bytes got %h %h %h %h want 12 34 56 78", mem0[32], mem0[33], mem0[34], mem0[35]);
    end
    sb.push_back('{rdata: 32'h1234_5678, err: 1'b0, lat: 5});
    run_req(0, RW_READ, 32'h20, 32'h0, 0, rd, er, lt);
    e = sb.pop_front();
    total++; if (rd !== e.rdata) begin bad++; $display("FAIL readback_20 got %h want %h", rd, e.rdata); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er; int lt; exp_t e; int base; bit ok; int nlog;
    preload(1, 7'h0C, 32'hA1B2_C3D4);
    base = addr_log2.size();
    sb.push_back('{rdata: 32'hA1B2_C3D4, err: 1'b0, lat: 13});
    run_req(1, RW_READ, 32'h0C, 32'h0, 1, rd, er, lt);
    e = sb.pop_front();
    total++; if (rd !== e.rdata) begin bad++; $display("FAIL ws2_rdata got %h want %h", rd, e.rdata); end
    total++; if (er !== e.err)   begin bad++; $display("FAIL ws2_err got %b want %b", er, e.err); end
    total++; if (lt !== e.lat)   begin bad++; $display("FAIL ws2_latency got %0d want %0d", lt, e.lat); end
    nlog = addr_log2.size() - base;
    ok = (nlog == 12);
    for (int i = 0; i < 12 && ok; i++)
      if (addr_log2[base+i] !== 32'h0C + 32'(i / 3)) ok = 0;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL ws2_addr_hold got %0d cycles or wrong addr, want 0c x3 0d x3 0e x3 0f x3", nlog); end
  endtask

  task automatic test_range_err();
    logic [31:0] rd; logic er; int lt; exp_t e; int base;
    base = en_cnt0;
    sb.push_back('{rdata: 32'h0, err: 1'b1, lat: 1});
    run_req(0, RW_READ, 32'h7D, 32'h0, 0, rd, er, lt);
    e = sb.pop_front();
    total++; if (er !== e.err)   begin bad++; $display("FAIL range_7d_err got %b want %b", er, e.err); end
    total++; if (rd !== e.rdata) begin bad++; $display("FAIL range_7d_rdata got %h want %h", rd, e.rdata); end
    total++; if (lt !== e.lat)   begin bad++; $display("FAIL range_7d_latency got %0d want %0d", lt, e.lat); end
    total++; if (en_cnt0 - base !== 0) begin bad++; $display("FAIL range_7d_mem_en got %0d want 0", en_cnt0 - base); end
    sb.push_back('{rdata: 32'h0, err: 1'b1, lat: 1});
    run_req(0, RW_WRITE, 32'hFFFF_FFFC, 32'h5555_5555, 0, rd, er, lt);
    e = sb.pop_front();
    total++; if (er !== e.err || lt !== e.lat) begin bad++; $display("FAIL range_high_write got err=%b lat=%0d want err=%b lat=%0d", er, lt, e.err, e.lat); end
    preload(0, 7'h7C, 32'hDEAD_BEEF);
    sb.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0, lat: 5});
    run_req(0, RW_READ, 32'h7C, 32'h0, 0, rd, er, lt);
    e = sb.pop_front();
    total++; if (rd !== e.rdata || er !== e.err) begin bad++; $display("FAIL range_7c_edge got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
  endtask

  task automatic test_unaligned();
    logic [31:0] rd; logic er; int lt; exp_t e; int base; int exp_en;
    preload(0, 7'h02, 32'h5A6B_7C8D);
    base = en_cnt0;
`ifdef CPU0_MEM_ALIGN_CHECK_EN
    sb.push_back('{rdata: 32'h0, err: 1'b1, lat: 1});
    exp_en = 0;
`else
    sb.push_back('{rdata: 32'h5A6B_7C8D, err: 1'b0, lat: 5});
    exp_en = 4;
`endif
    run_req(0, RW_READ, 32'h02, 32'h0, 0, rd, er, lt);
    e = sb.pop_front();
    total++; if (rd !== e.rdata || er !== e.err) begin bad++; $display("FAIL unaligned_02 got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
    total++; if (en_cnt0 - base !== exp_en) begin bad++; $display("FAIL unaligned_02_mem_en got %0d want %0d", en_cnt0 - base, exp_en); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lt; exp_t e;
    logic [31:0] w [3];
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom;
      sb.push_back('{rdata: 32'h0, err: 1'b0, lat: 5});
    end
    for (int i = 0; i < 3; i++) sb.push_back('{rdata: w[i], err: 1'b0, lat: 5});
    for (int i = 0; i < 6; i++) begin
      run_req(0, (i >= 3) ? RW_READ : RW_WRITE, 32'h40 + 32'(4 * (i % 3)), w[i % 3], 0, rd, er, lt);
      e = sb.pop_front();
      total++;
      if (rd !== e.rdata || er !== e.err || lt !== e.lat) begin
        bad++;
        $display("FAIL b2b_%0d got %h/%b/%0d want %h/%b/%0d", i, rd, er, lt, e.rdata, e.err, e.lat);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lt; exp_t e;
    preload(0, 7'h10, 32'h1122_AABB);
    @(negedge clock);
    drive(0, 1'b1, RW_WRITE, 32'h10, 32'hCAFE_F00D);
    @(posedge clock);                 // accept
    @(negedge clock);
    drive(0, 1'b0, RW_WRITE, 32'h10, 32'hCAFE_F00D);
    @(posedge clock);                 // byte 0 written
    @(posedge clock);                 // byte 1 written
    @(negedge clock);                 // inside byte 2
    total++; if (if0.mem_addr !== 32'h12) begin bad++; $display("FAIL midreset_phase got %h want 00000012", if0.mem_addr); end
    reset = 1'b0;
    #1;
    total++;
    if ({if0.req_ready, if0.req_err, if0.req_rdata, if0.mem_en, if0.mem_rw,
         if0.mem_addr, if0.mem_wdata} !== 76'd0) begin
      bad++;
      $display("FAIL midreset_outputs got mem_en=%b addr=%h wdata=%h want 0", if0.mem_en, if0.mem_addr, if0.mem_wdata);
    end
    @(negedge clock);
    reset = 1'b1;
    total++;
    if ({mem0[16], mem0[17], mem0[18], mem0[19]} !== 32'hCAFE_AABB) begin
      bad++;
      $display("FAIL midreset_bytes got %h %h %h %h want ca fe aa bb", mem0[16], mem0[17], mem0[18], mem0[19]);
    end
    sb.push_back('{rdata: 32'hCAFE_AABB, err: 1'b0, lat: 5});
    run_req(0, RW_READ, 32'h10, 32'h0, 0, rd, er, lt);
    e = sb.pop_front();
    total++; if (rd !== e.rdata || er !== e.err || lt !== e.lat) begin bad++; $display("FAIL midreset_recover got %h/%b/%0d want %h/%b/%0d", rd, er, lt, e.rdata, e.err, e.lat); end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_readback();
    test_wait_states();
    test_range_err();
    test_unaligned();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
